// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO stack: operation encoding
// and a constant-evaluable ceil(log2()) helper for sizing counters/addresses.
package lifo_pkg;

  // One operation is performed per cycle. Rejected requests (push while full,
  // pop while empty) decode to OP_NOP and raise an error flag instead.
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_BYPASS  = 3'd4
  } op_e;

  // ceil(log2(n)); usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// DEPTH x WIDTH storage for the LIFO: synchronous write, asynchronous read,
// independent write and read addresses.
module lifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             Clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: one word per cycle on the rising edge.
  // NOTE: storage has no reset; its contents are only ever read below the
  // occupancy count, so resetting it would cost logic for no behaviour.
  always_ff @(posedge Clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack: op decode, occupancy count, registered pop-data
// port with valid pulse, combinational peek, status and sticky error flags.
module param_lifo_stack
  import lifo_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int AFULL_LVL = DEPTH - 2,
  localparam int CNT_W     = clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] peek_o,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int             AW        = clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_data_o;
  logic             r_valid_o;
  logic             r_overflow;
  logic             r_underflow;

  op_e              w_op;
  logic             w_ovf;
  logic             w_unf;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_top_idx;
  logic [AW-1:0]    w_rd_addr;
  logic [AW-1:0]    w_wr_addr;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_rd_data;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_CNT);
  // Top index is only meaningful when non-empty; otherwise park at 0 so the
  // read address never leaves the storage range.
  assign w_top_idx = r_count - CNT_W'(1);
  assign w_rd_addr = w_empty ? '0 : w_top_idx[AW-1:0];

  // Decode the request strobes against the current occupancy.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_op  = OP_NOP;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    case ({push, pop})
      2'b11: w_op = w_empty ? OP_BYPASS : OP_REPLACE;
      2'b10: begin
        if (w_full) w_ovf = 1'b1;
        else        w_op  = OP_PUSH;
      end
      2'b01: begin
        if (w_empty) w_unf = 1'b1;
        else         w_op  = OP_POP;
      end
      default: w_op = OP_NOP;
    endcase
  end

  // A push writes one above the top; a replace overwrites the top in place.
  assign w_wr_en   = (w_op == OP_PUSH) || (w_op == OP_REPLACE);
  assign w_wr_addr = (w_op == OP_REPLACE) ? w_rd_addr : r_count[AW-1:0];

  lifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .Clk      (Clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(data_i),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  // Occupancy: only plain push and plain pop change the count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_PUSH: r_count <= r_count + CNT_W'(1);
        OP_POP:  r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pop-data register with a single-cycle valid pulse per accepted pop.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
    end else begin
      r_valid_o <= (w_op == OP_POP) || (w_op == OP_REPLACE) || (w_op == OP_BYPASS);
      if ((w_op == OP_POP) || (w_op == OP_REPLACE)) begin
        r_data_o <= w_rd_data;
      end else if (w_op == OP_BYPASS) begin
        r_data_o <= data_i;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle beats clr_err.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf)        r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_unf)        r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

  assign count       = r_count;
  assign data_o      = r_data_o;
  assign valid_o     = r_valid_o;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= AFULL_CNT);
  assign peek_o      = w_empty ? '0 : w_rd_data;

endmodule
